// File: rtl/rng_request_arbiter_pkg.sv
// Shared FSM encoding, sizing helpers and defaults for the RNG request arbiter.
package rng_request_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;
  // Wait counter wide enough for the largest supported generator latency (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rng_request_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request bit at or after ptr, wrapping.
module rr_priority_picker
  import rng_request_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_any,
  output logic [ID_W-1:0]  o_idx
);

  logic [N_REQ-1:0] w_rot;
  logic [ID_W-1:0]  w_off;
  logic [ID_W:0]    w_sum;

  // Rotate so bit 0 of w_rot is the requester sitting at the pointer.
  assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);

  // Scan from the far end so the set bit nearest the pointer is written last.
  always_comb begin
    w_off = {ID_W{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_off = w_rot[k] ? ID_W'(k) : w_off;
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_any = |i_req;
  assign o_idx = (w_sum >= (ID_W + 1)'(N_REQ)) ? ID_W'(w_sum - (ID_W + 1)'(N_REQ))
                                               : w_sum[ID_W-1:0];

endmodule

// File: rtl/rng_request_arbiter.sv
// Shares one random generator among N_REQ requesters with round-robin arbitration,
// a fixed-latency capture of the generator output and a one-hot grant pulse.
module rng_request_arbiter
  import rng_request_arbiter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int N_REQ       = 4,
  parameter int GEN_LATENCY = 1,
  parameter int ID_W        = clog2(N_REQ)
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic [N_REQ-1:0]        in_req,
  input  logic [N_REQ*WIDTH-1:0]  in_min,
  input  logic [N_REQ*WIDTH-1:0]  in_max,
  output logic [N_REQ-1:0]        out_grant,
  output logic [ID_W-1:0]         out_grant_id,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_random,
  output logic                    out_range_error,
  output logic                    out_gen_enable,
  output logic signed [WIDTH-1:0] out_gen_min,
  output logic signed [WIDTH-1:0] out_gen_max,
  input  logic signed [WIDTH-1:0] in_gen_random
);

  localparam logic [N_REQ-1:0] GRANT_LSB = {{(N_REQ - 1){1'b0}}, 1'b1};

  state_e                  r_state;
  logic [ID_W-1:0]         r_rr_ptr;
  logic [ID_W-1:0]         r_id;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_any;
  logic [ID_W-1:0]         w_idx;
  logic signed [WIDTH-1:0] w_min_arr [N_REQ];
  logic signed [WIDTH-1:0] w_max_arr [N_REQ];
  logic signed [WIDTH-1:0] w_min_sel;
  logic signed [WIDTH-1:0] w_max_sel;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign w_min_arr[g] = in_min[g*WIDTH +: WIDTH];
    assign w_max_arr[g] = in_max[g*WIDTH +: WIDTH];
  end

  assign w_min_sel = w_min_arr[w_idx];
  assign w_max_sel = w_max_arr[w_idx];

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .i_req (in_req),
    .i_ptr (r_rr_ptr),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  // Controller: outputs are written on the edge that enters the state they belong to,
  // so out_gen_min/max double as the latched bounds for the whole transaction.
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      r_state         <= ST_IDLE;
      r_rr_ptr        <= {ID_W{1'b0}};
      r_id            <= {ID_W{1'b0}};
      r_cnt           <= {CNT_W{1'b0}};
      out_grant       <= {N_REQ{1'b0}};
      out_grant_id    <= {ID_W{1'b0}};
      out_valid       <= 1'b0;
      out_random      <= {WIDTH{1'b0}};
      out_range_error <= 1'b0;
      out_gen_enable  <= 1'b0;
      out_gen_min     <= {WIDTH{1'b0}};
      out_gen_max     <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id <= w_idx;
            if (w_min_sel > w_max_sel) begin
              // Inverted range: skip the generator and return min flagged as an error.
              out_random      <= w_min_sel;
              out_valid       <= 1'b1;
              out_grant       <= GRANT_LSB << w_idx;
              out_grant_id    <= w_idx;
              out_range_error <= 1'b1;
              r_state         <= ST_DELIVER;
            end else begin
              out_gen_enable  <= 1'b1;
              out_gen_min     <= w_min_sel;
              out_gen_max     <= w_max_sel;
              r_state         <= ST_ISSUE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          out_gen_enable <= 1'b0;
          r_cnt          <= CNT_W'(GEN_LATENCY);
          r_state        <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            out_random      <= in_gen_random;
            out_valid       <= 1'b1;
            out_grant       <= GRANT_LSB << r_id;
            out_grant_id    <= r_id;
            out_range_error <= 1'b0;
            r_state         <= ST_DELIVER;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_DELIVER: begin
          out_valid       <= 1'b0;
          out_grant       <= {N_REQ{1'b0}};
          out_grant_id    <= {ID_W{1'b0}};
          out_range_error <= 1'b0;
          r_rr_ptr        <= (r_id == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : r_id + ID_W'(1);
          r_state         <= ST_IDLE;
        end
        default: begin
          out_valid       <= 1'b0;
          out_grant       <= {N_REQ{1'b0}};
          out_gen_enable  <= 1'b0;
          out_range_error <= 1'b0;
          r_state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_request_arbiter.sv
// Self-checking bench for rng_request_arbiter with a stub generator and a round-robin reference model.
module tb_rng_request_arbiter;

  localparam int W = 32;
  localparam int N = 4;
  localparam int L = 1;

  logic                in_clock = 1'b0;
  logic                in_reset;
  logic [N-1:0]        in_req;
  logic [N*W-1:0]      in_min;
  logic [N*W-1:0]      in_max;
  logic [N-1:0]        out_grant;
  logic [1:0]          out_grant_id;
  logic                out_valid;
  logic signed [W-1:0] out_random;
  logic                out_range_error;
  logic                out_gen_enable;
  logic signed [W-1:0] out_gen_min;
  logic signed [W-1:0] out_gen_max;
  logic signed [W-1:0] in_gen_random = 32'sd0;

  int bmin [N];
  int bmax [N];
  int n_pass  = 0;
  int n_total = 0;
  int exp_ptr = 0;

  logic gen_force     = 1'b0;
  int   gen_force_val = 0;
  int   gen_en_count  = 0;
  int   last_lo       = 0;
  int   last_hi       = 0;

  always #5 in_clock = ~in_clock;

  assign in_min = {32'(bmin[3]), 32'(bmin[2]), 32'(bmin[1]), 32'(bmin[0])};
  assign in_max = {32'(bmax[3]), 32'(bmax[2]), 32'(bmax[1]), 32'(bmax[0])};

  rng_request_arbiter #(.WIDTH(W), .N_REQ(N), .GEN_LATENCY(L)) dut (
    .in_clock        (in_clock),
    .in_reset        (in_reset),
    .in_req          (in_req),
    .in_min          (in_min),
    .in_max          (in_max),
    .out_grant       (out_grant),
    .out_grant_id    (out_grant_id),
    .out_valid       (out_valid),
    .out_random      (out_random),
    .out_range_error (out_range_error),
    .out_gen_enable  (out_gen_enable),
    .out_gen_min     (out_gen_min),
    .out_gen_max     (out_gen_max),
    .in_gen_random   (in_gen_random)
  );

  function automatic int gen_value(input int lo, input int hi);
    int span;
    if (gen_force) return gen_force_val;
    span = hi - lo;
    if (span < 0) span = 0;
    return lo + int'($urandom_range(0, span));
  endfunction

  // Stub generator: samples enable on a clock edge, result valid one cycle later.
  always @(posedge in_clock) begin
    if (out_gen_enable === 1'b1) begin
      in_gen_random <= gen_value(out_gen_min, out_gen_max);
      gen_en_count  <= gen_en_count + 1;
      last_lo       <= out_gen_min;
      last_hi       <= out_gen_max;
    end
  end

  // Reference arbitration: first requester at or after ptr, wrapping.
  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (ptr + k) % N;
      if (((int'(req) >> c) & 1) == 1) return c;
    end
    return -1;
  endfunction

  // Called at a negedge; counts rising edges until out_valid is seen.
  task automatic wait_grant(input int budget, output int cycles, output bit got);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(posedge in_clock);
      cycles++;
      @(negedge in_clock);
      if (out_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic do_reset();
    in_reset = 1'b0;
    in_req = 4'b0000;
    repeat (2) @(posedge in_clock);
    @(negedge in_clock);
    in_reset = 1'b1;
    exp_ptr = 0;
  endtask

  task automatic test_reset();
    int base, cyc, e;
    bit got;
    @(negedge in_clock);
    base = gen_en_count;
    in_reset = 1'b0;
    in_req = 4'b1111;
    repeat (2) @(posedge in_clock);
    @(negedge in_clock);
    n_total++;
    if (out_grant !== 4'b0 || out_grant_id !== 2'b0 || out_valid !== 1'b0 || out_random !== 32'sd0 ||
        out_range_error !== 1'b0 || out_gen_enable !== 1'b0 || out_gen_min !== 32'sd0 || out_gen_max !== 32'sd0)
      $display("FAIL reset_outputs: grant=%b id=%0d valid=%b rnd=%0d err=%b en=%b min=%0d max=%0d, required all 0",
               out_grant, out_grant_id, out_valid, out_random, out_range_error, out_gen_enable, out_gen_min, out_gen_max);
    else n_pass++;
    n_total++;
    if (gen_en_count !== base) $display("FAIL reset_no_enable: enables=%0d required 0", gen_en_count - base);
    else n_pass++;
    in_reset = 1'b1;
    exp_ptr = 0;
    e = model_pick(in_req, exp_ptr);
    wait_grant(20, cyc, got);
    n_total++;
    if (!got || cyc != 2 + L) $display("FAIL reset_first_latency: got=%0d cycles=%0d required 1/%0d", got, cyc, 2 + L);
    else n_pass++;
    n_total++;
    if (out_grant_id !== 2'(e) || out_grant !== 4'(1 << e))
      $display("FAIL reset_first_grant: id=%0d grant=%b required id=%0d", out_grant_id, out_grant, e);
    else n_pass++;
    in_req = 4'b0000;
    exp_ptr = (e + 1) % N;
    @(negedge in_clock);
  endtask

  task automatic test_single();
    int base, cyc;
    bit got;
    bmin[2] = 0;
    bmax[2] = 5;
    gen_force = 1'b1;
    gen_force_val = 3;
    base = gen_en_count;
    in_req = 4'b0100;
    wait_grant(20, cyc, got);
    n_total++;
    if (!got || cyc != 2 + L) $display("FAIL single_latency: got=%0d cycles=%0d required 1/%0d", got, cyc, 2 + L);
    else n_pass++;
    n_total++;
    if (out_grant !== 4'b0100 || out_grant_id !== 2'd2)
      $display("FAIL single_grant: grant=%b id=%0d required 0100/2", out_grant, out_grant_id);
    else n_pass++;
    n_total++;
    if (out_random !== 32'sd3 || out_range_error !== 1'b0)
      $display("FAIL single_data: rnd=%0d err=%b required 3/0", out_random, out_range_error);
    else n_pass++;
    n_total++;
    if (gen_en_count - base != 1 || last_lo != 0 || last_hi != 5)
      $display("FAIL single_gen_issue: enables=%0d min=%0d max=%0d required 1/0/5", gen_en_count - base, last_lo, last_hi);
    else n_pass++;
    gen_force = 1'b0;
    in_req = 4'b0000;
    exp_ptr = 3;
    @(negedge in_clock);
  endtask

  task automatic test_fairness();
    int cyc, e;
    bit got;
    do_reset();
    bmin[0] = -20; bmax[0] = -10;
    bmin[1] = -20; bmax[1] = 2;
    bmin[2] = 20;  bmax[2] = 26;
    bmin[3] = 0;   bmax[3] = 5;
    in_req = 4'b1111;
    for (int t = 0; t < 16; t++) begin
      e = model_pick(in_req, exp_ptr);
      wait_grant(20, cyc, got);
      n_total++;
      if (!got || cyc != ((t == 0) ? 2 + L : 3 + L))
        $display("FAIL fair_latency[%0d]: got=%0d cycles=%0d required %0d", t, got, cyc, (t == 0) ? 2 + L : 3 + L);
      else n_pass++;
      n_total++;
      if (out_grant_id !== 2'(e) || out_grant !== 4'(1 << e))
        $display("FAIL fair_order[%0d]: id=%0d grant=%b required id=%0d", t, out_grant_id, out_grant, e);
      else n_pass++;
      n_total++;
      if (!(out_random >= bmin[e] && out_random <= bmax[e]) || out_random !== in_gen_random || out_range_error !== 1'b0)
        $display("FAIL fair_range[%0d]: rnd=%0d err=%b required %0d in [%0d,%0d]", t, out_random, out_range_error,
                 in_gen_random, bmin[e], bmax[e]);
      else n_pass++;
      exp_ptr = (e + 1) % N;
      if (t == 15) in_req = 4'b0000;
    end
    @(negedge in_clock);
  endtask

  task automatic test_range_error();
    int base, cyc;
    bit got;
    bmin[1] = 7;  bmax[1] = -3;
    bmin[2] = 20; bmax[2] = 26;
    base = gen_en_count;
    in_req = 4'b0110;
    wait_grant(20, cyc, got);
    n_total++;
    if (!got || cyc != 1 || out_grant_id !== 2'd1 || out_grant !== 4'b0010)
      $display("FAIL err_grant: got=%0d cycles=%0d id=%0d grant=%b required 1/1/1/0010", got, cyc, out_grant_id, out_grant);
    else n_pass++;
    n_total++;
    if (out_range_error !== 1'b1 || out_random !== 32'sd7 || gen_en_count != base)
      $display("FAIL err_data: err=%b rnd=%0d enables=%0d required 1/7/0", out_range_error, out_random, gen_en_count - base);
    else n_pass++;
    in_req = 4'b0100;
    exp_ptr = 2;
    wait_grant(20, cyc, got);
    n_total++;
    if (!got || cyc != 3 + L || out_grant_id !== 2'(model_pick(4'b0100, exp_ptr)) || out_grant !== 4'b0100)
      $display("FAIL err_next_grant: got=%0d cycles=%0d id=%0d required 1/%0d/2", got, cyc, out_grant_id, 3 + L);
    else n_pass++;
    n_total++;
    if (out_range_error !== 1'b0 || !(out_random >= 20 && out_random <= 26) || gen_en_count - base != 1)
      $display("FAIL err_next_data: err=%b rnd=%0d enables=%0d required 0/[20,26]/1", out_range_error, out_random,
               gen_en_count - base);
    else n_pass++;
    in_req = 4'b0000;
    exp_ptr = 3;
    @(negedge in_clock);
  endtask

  task automatic test_withdrawal();
    int base, cyc, nvalid;
    bit got;
    bmin[3] = -8;
    bmax[3] = -2;
    in_req = 4'b1000;
    @(posedge in_clock);
    @(negedge in_clock);
    n_total++;
    if (out_gen_enable !== 1'b1 || out_gen_min !== -32'sd8 || out_gen_max !== -32'sd2)
      $display("FAIL wd_issue: en=%b min=%0d max=%0d required 1/-8/-2", out_gen_enable, out_gen_min, out_gen_max);
    else n_pass++;
    @(posedge in_clock);
    @(negedge in_clock);
    in_req = 4'b0000;
    bmin[3] = 100;
    bmax[3] = 200;
    wait_grant(20, cyc, got);
    n_total++;
    if (!got || cyc != 1 || out_grant !== 4'b1000 || out_grant_id !== 2'd3)
      $display("FAIL wd_grant: got=%0d cycles=%0d grant=%b required 1/1/1000", got, cyc, out_grant);
    else n_pass++;
    n_total++;
    if (!(out_random >= -8 && out_random <= -2) || out_random !== in_gen_random)
      $display("FAIL wd_data: rnd=%0d required %0d in [-8,-2]", out_random, in_gen_random);
    else n_pass++;
    exp_ptr = 0;
    @(negedge in_clock);
    bmin[0] = 1; bmax[0] = 4;
    bmin[2] = 0; bmax[2] = 5;
    base = gen_en_count;
    in_req = 4'b0101;
    @(posedge in_clock);
    @(negedge in_clock);
    in_req = 4'b0001;
    wait_grant(20, cyc, got);
    n_total++;
    if (!got || cyc != 1 + L || out_grant_id !== 2'(model_pick(4'b0101, exp_ptr)))
      $display("FAIL wd_busy_grant: got=%0d cycles=%0d id=%0d required 1/%0d/0", got, cyc, out_grant_id, 1 + L);
    else n_pass++;
    in_req = 4'b0000;
    exp_ptr = 1;
    nvalid = 0;
    repeat (12) begin
      @(negedge in_clock);
      if (out_valid !== 1'b0) nvalid++;
    end
    n_total++;
    if (nvalid != 0 || gen_en_count - base != 1)
      $display("FAIL wd_dropped_unserved: extra_valids=%0d enables=%0d required 0/1", nvalid, gen_en_count - base);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int cyc, nvalid;
    bit got;
    bmin[1] = -5;
    bmax[1] = 5;
    in_req = 4'b0010;
    @(posedge in_clock);
    @(negedge in_clock);
    @(posedge in_clock);
    @(negedge in_clock);
    in_reset = 1'b0;
    in_req = 4'b0000;
    @(posedge in_clock);
    @(negedge in_clock);
    n_total++;
    if (out_grant !== 4'b0 || out_valid !== 1'b0 || out_gen_enable !== 1'b0 || out_random !== 32'sd0 ||
        out_gen_min !== 32'sd0 || out_gen_max !== 32'sd0)
      $display("FAIL midrst_outputs: grant=%b valid=%b en=%b rnd=%0d min=%0d max=%0d required all 0",
               out_grant, out_valid, out_gen_enable, out_random, out_gen_min, out_gen_max);
    else n_pass++;
    in_reset = 1'b1;
    exp_ptr = 0;
    nvalid = 0;
    repeat (8) begin
      @(negedge in_clock);
      if (out_valid !== 1'b0) nvalid++;
    end
    n_total++;
    if (nvalid != 0) $display("FAIL midrst_no_grant: valids=%0d required 0", nvalid);
    else n_pass++;
    in_req = 4'b1111;
    wait_grant(20, cyc, got);
    n_total++;
    if (!got || cyc != 2 + L || out_grant_id !== 2'(model_pick(4'b1111, exp_ptr)) || out_grant !== 4'b0001)
      $display("FAIL midrst_restart: got=%0d cycles=%0d id=%0d required 1/%0d/0", got, cyc, out_grant_id, 2 + L);
    else n_pass++;
    in_req = 4'b0000;
    exp_ptr = 1;
    @(negedge in_clock);
  endtask

  task automatic test_random();
    int base, cyc, e;
    bit got, exp_err;
    logic [N-1:0] r;
    for (int t = 0; t < 24; t++) begin
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        bmin[i] = int'($urandom_range(0, 100)) - 50;
        if ($urandom_range(0, 4) == 0) bmax[i] = bmin[i] - 1 - int'($urandom_range(0, 20));
        else bmax[i] = bmin[i] + int'($urandom_range(0, 30));
      end
      base = gen_en_count;
      in_req = r;
      e = model_pick(r, exp_ptr);
      exp_err = (bmin[e] > bmax[e]);
      wait_grant(20, cyc, got);
      n_total++;
      if (!got || cyc != (exp_err ? 1 : 2 + L) || out_grant_id !== 2'(e) || out_grant !== 4'(1 << e))
        $display("FAIL rand_grant[%0d]: got=%0d cycles=%0d id=%0d grant=%b required id=%0d req=%b", t, got, cyc,
                 out_grant_id, out_grant, e, r);
      else n_pass++;
      n_total++;
      if (exp_err) begin
        if (out_range_error !== 1'b1 || out_random !== bmin[e] || gen_en_count != base)
          $display("FAIL rand_err[%0d]: err=%b rnd=%0d enables=%0d required 1/%0d/0", t, out_range_error, out_random,
                   gen_en_count - base, bmin[e]);
        else n_pass++;
      end else begin
        if (out_range_error !== 1'b0 || out_random !== in_gen_random || !(out_random >= bmin[e] && out_random <= bmax[e]) ||
            gen_en_count - base != 1)
          $display("FAIL rand_data[%0d]: err=%b rnd=%0d enables=%0d required 0/%0d in [%0d,%0d]/1", t, out_range_error,
                   out_random, gen_en_count - base, in_gen_random, bmin[e], bmax[e]);
        else n_pass++;
      end
      in_req = 4'b0000;
      exp_ptr = (e + 1) % N;
      @(negedge in_clock);
    end
  endtask

  initial begin
    in_reset = 1'b0;
    in_req = 4'b0000;
    for (int i = 0; i < N; i++) begin
      bmin[i] = 0;
      bmax[i] = 0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_range_error();
    test_withdrawal();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
